// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Package     : core_pkg
// Description : Shared constants for the 5-stage core: opcodes, forwarding
//               select encodings, sequencing-controller states and the
//               source-register usage decode.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    // Base RV32I major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // EX operand select encodings
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Sequencing-controller states
    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MDU_WAIT = 1'b1;

    // Instructions that read rs1 (register-register, store, branch, jalr, op-imm, load)
    function automatic logic uses_rs1(input logic [6:0] op);
        return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH) ||
               (op == OP_JALR) || (op == OP_I) || (op == OP_LOAD);
    endfunction

    // Instructions that read rs2 (register-register, store, branch)
    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage : core_pkg
`default_nettype wire

// File: rtl/fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : fwd_unit
// Description : Purely combinational forwarding selects. EX operands prefer
//               the younger MEM result over WB; ID reads are bypassed from WB
//               because the register file is not write-through.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_unit
    import core_pkg::*;
(
    input  logic [4:0] rs1_ex_i,
    input  logic [4:0] rs2_ex_i,
    input  logic [4:0] rs1_id_i,
    input  logic [4:0] rs2_id_i,
    input  logic [4:0] rd_mem_i,
    input  logic [4:0] rd_wb_i,
    input  logic       regwrite_mem_i,
    input  logic       regwrite_wb_i,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o,
    output logic       fwd_id_a_o,
    output logic       fwd_id_b_o
);

    // x0 is hardwired to zero, so a write to it never produces a forwardable value
    logic mem_live;
    logic wb_live;

    assign mem_live = regwrite_mem_i && (rd_mem_i != 5'd0);
    assign wb_live  = regwrite_wb_i  && (rd_wb_i  != 5'd0);

    // EX operand selects: MEM result is newer than WB, so it wins
    always_comb begin
        fwd_a_o = FWD_REG;
        if (mem_live && (rd_mem_i == rs1_ex_i)) begin
            fwd_a_o = FWD_MEM;
        end else if (wb_live && (rd_wb_i == rs1_ex_i)) begin
            fwd_a_o = FWD_WB;
        end

        fwd_b_o = FWD_REG;
        if (mem_live && (rd_mem_i == rs2_ex_i)) begin
            fwd_b_o = FWD_MEM;
        end else if (wb_live && (rd_wb_i == rs2_ex_i)) begin
            fwd_b_o = FWD_WB;
        end
    end

    assign fwd_id_a_o = wb_live && (rd_wb_i == rs1_id_i);
    assign fwd_id_b_o = wb_live && (rd_wb_i == rs2_id_i);

endmodule : fwd_unit
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline sequencing controller. Produces PC/IF_ID/ID_EX write
//               enables and bubble strobes for branch redirects, load-use
//               hazards and multi-cycle MDU operations (with timeout), the
//               forwarding selects, and saturating stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       OPCODE_ID,
    input  logic [4:0]       RS1_ID,
    input  logic [4:0]       RS2_ID,
    input  logic [4:0]       RS1_EX,
    input  logic [4:0]       RS2_EX,
    input  logic [4:0]       RD_EX,
    input  logic [4:0]       RD_MEM,
    input  logic [4:0]       RD_WB,
    input  logic             MemRead_EX,
    input  logic             RegWrite_EX,
    input  logic             RegWrite_MEM,
    input  logic             RegWrite_WB,
    input  logic             PCSrc_EX,
    input  logic             MDU_START_EX,
    input  logic             MDU_DONE,
    output logic             PC_WRITE,
    output logic             IF_ID_WRITE,
    output logic             ID_EX_WRITE,
    output logic             IF_ID_FLUSH,
    output logic             ID_EX_FLUSH,
    output logic             EX_MEM_FLUSH,
    output logic [1:0]       FWD_A,
    output logic [1:0]       FWD_B,
    output logic             FWD_ID_A,
    output logic             FWD_ID_B,
    output logic             MDU_ABORT,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    // Wait counter only needs to reach MDU_TIMEOUT-1
    localparam int            TW   = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [TW-1:0] TLIM = TW'(MDU_TIMEOUT - 1);

    logic [0:0]       state_q, state_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic [CNT_W-1:0] stall_q, flush_q;

    logic             load_use;
    logic             stall_inc;
    logic             flush_inc;
    logic [1:0]       fwd_a, fwd_b;
    logic             fwd_id_a, fwd_id_b;

    // RegWrite_EX is carried for interface completeness; load-use uses MemRead_EX
    logic             unused_ok;
    assign unused_ok = RegWrite_EX;

    // Load in EX whose destination is read by the instruction in ID
    assign load_use = MemRead_EX && (RD_EX != 5'd0) &&
                      ((uses_rs1(OPCODE_ID) && (RD_EX == RS1_ID)) ||
                       (uses_rs2(OPCODE_ID) && (RD_EX == RS2_ID)));

    fwd_unit u_fwd (
        .rs1_ex_i       (RS1_EX),
        .rs2_ex_i       (RS2_EX),
        .rs1_id_i       (RS1_ID),
        .rs2_id_i       (RS2_ID),
        .rd_mem_i       (RD_MEM),
        .rd_wb_i        (RD_WB),
        .regwrite_mem_i (RegWrite_MEM),
        .regwrite_wb_i  (RegWrite_WB),
        .fwd_a_o        (fwd_a),
        .fwd_b_o        (fwd_b),
        .fwd_id_a_o     (fwd_id_a),
        .fwd_id_b_o     (fwd_id_b)
    );

    // Forwarding is independent of the FSM but held at regfile while in reset
    assign FWD_A    = rst_n ? fwd_a    : FWD_REG;
    assign FWD_B    = rst_n ? fwd_b    : FWD_REG;
    assign FWD_ID_A = rst_n && fwd_id_a;
    assign FWD_ID_B = rst_n && fwd_id_b;

    // State and MDU wait counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Next state: branch redirect outranks MDU issue; DONE outranks timeout
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            ST_RUN: begin
                if (!PCSrc_EX && MDU_START_EX) begin
                    state_d = ST_MDU_WAIT;
                    tcnt_d  = '0;
                end
            end
            ST_MDU_WAIT: begin
                if (MDU_DONE || (tcnt_q == TLIM)) begin
                    state_d = ST_RUN;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Strobes and counter increments, all zero-latency from current inputs
    always_comb begin
        PC_WRITE     = 1'b1;
        IF_ID_WRITE  = 1'b1;
        ID_EX_WRITE  = 1'b1;
        IF_ID_FLUSH  = 1'b0;
        ID_EX_FLUSH  = 1'b0;
        EX_MEM_FLUSH = 1'b0;
        MDU_ABORT    = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (!rst_n) begin
            PC_WRITE     = 1'b0;
            IF_ID_WRITE  = 1'b0;
            ID_EX_WRITE  = 1'b0;
            IF_ID_FLUSH  = 1'b1;
            ID_EX_FLUSH  = 1'b1;
            EX_MEM_FLUSH = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (PCSrc_EX) begin
                        IF_ID_FLUSH = 1'b1;
                        ID_EX_FLUSH = 1'b1;
                        flush_inc   = 1'b1;
                    end else if (MDU_START_EX) begin
                        // Issue cycle proceeds normally; the freeze starts next cycle
                    end else if (load_use) begin
                        PC_WRITE    = 1'b0;
                        IF_ID_WRITE = 1'b0;
                        ID_EX_FLUSH = 1'b1;
                        stall_inc   = 1'b1;
                    end
                end
                ST_MDU_WAIT: begin
                    if (MDU_DONE) begin
                        // Release with normal strobes
                    end else if (tcnt_q == TLIM) begin
                        MDU_ABORT = 1'b1;
                    end else begin
                        PC_WRITE     = 1'b0;
                        IF_ID_WRITE  = 1'b0;
                        ID_EX_WRITE  = 1'b0;
                        EX_MEM_FLUSH = 1'b1;
                        stall_inc    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_inc && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (flush_inc && (flush_q != '1)) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign STALL_CNT = stall_q;
    assign FLUSH_CNT = flush_q;

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Scoreboard bench for hazard_ctrl. A driver applies one input
//               vector per cycle and pushes the reference model's expectation;
//               a monitor pops and compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
    import core_pkg::*;

    localparam int T  = 8;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic       rst_n;
        logic [6:0] op;
        logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
        logic       memread, rw_ex, rw_mem, rw_wb, pcsrc, start, done;
    } stim_t;

    typedef struct {
        logic [2:0] wr;     // {PC, IF_ID, ID_EX}
        logic [2:0] fl;     // {IF_ID, ID_EX, EX_MEM}
        logic [1:0] fa, fb;
        logic       fia, fib, abort;
        int         stall, flush;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [6:0] OPCODE_ID = '0;
    logic [4:0] RS1_ID = '0, RS2_ID = '0, RS1_EX = '0, RS2_EX = '0;
    logic [4:0] RD_EX = '0, RD_MEM = '0, RD_WB = '0;
    logic MemRead_EX = 0, RegWrite_EX = 0, RegWrite_MEM = 0, RegWrite_WB = 0;
    logic PCSrc_EX = 0, MDU_START_EX = 0, MDU_DONE = 0;
    logic PC_WRITE, IF_ID_WRITE, ID_EX_WRITE, IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH;
    logic [1:0] FWD_A, FWD_B;
    logic FWD_ID_A, FWD_ID_B, MDU_ABORT;
    logic [CW-1:0] STALL_CNT, FLUSH_CNT;

    always #5 clk = ~clk;

    hazard_ctrl #(.MDU_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .OPCODE_ID(OPCODE_ID),
        .RS1_ID(RS1_ID), .RS2_ID(RS2_ID), .RS1_EX(RS1_EX), .RS2_EX(RS2_EX),
        .RD_EX(RD_EX), .RD_MEM(RD_MEM), .RD_WB(RD_WB),
        .MemRead_EX(MemRead_EX), .RegWrite_EX(RegWrite_EX),
        .RegWrite_MEM(RegWrite_MEM), .RegWrite_WB(RegWrite_WB),
        .PCSrc_EX(PCSrc_EX), .MDU_START_EX(MDU_START_EX), .MDU_DONE(MDU_DONE),
        .PC_WRITE(PC_WRITE), .IF_ID_WRITE(IF_ID_WRITE), .ID_EX_WRITE(ID_EX_WRITE),
        .IF_ID_FLUSH(IF_ID_FLUSH), .ID_EX_FLUSH(ID_EX_FLUSH), .EX_MEM_FLUSH(EX_MEM_FLUSH),
        .FWD_A(FWD_A), .FWD_B(FWD_B), .FWD_ID_A(FWD_ID_A), .FWD_ID_B(FWD_ID_B),
        .MDU_ABORT(MDU_ABORT), .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
    );

    // ---------------- reference model (behavioural) ----------------
    bit   m_wait = 0;     // MDU op outstanding
    int   m_waited = 0;   // wait cycles already spent
    int   m_stall = 0, m_flush = 0;
    exp_t q[$];
    int   n_checks = 0, n_err = 0, cyc = 0;

    function automatic bit reads1(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0100011, 7'b1100011, 7'b1100111, 7'b0010011, 7'b0000011: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic bit reads2(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0100011, 7'b1100011: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [1:0] ex_sel(input stim_t s, input logic [4:0] rs);
        if (s.rw_mem && s.rd_mem != 0 && s.rd_mem == rs) return 2'd2;
        if (s.rw_wb && s.rd_wb != 0 && s.rd_wb == rs) return 2'd1;
        return 2'd0;
    endfunction

    task automatic model_step(input stim_t s, output exp_t e);
        bit lu;
        if (!s.rst_n) begin
            m_wait = 0; m_waited = 0; m_stall = 0; m_flush = 0;
            e.wr = 3'b000; e.fl = 3'b111; e.fa = 0; e.fb = 0;
            e.fia = 0; e.fib = 0; e.abort = 0; e.stall = 0; e.flush = 0;
            return;
        end
        e.stall = m_stall; e.flush = m_flush;
        e.fa  = ex_sel(s, s.rs1_ex);
        e.fb  = ex_sel(s, s.rs2_ex);
        e.fia = s.rw_wb && s.rd_wb != 0 && s.rd_wb == s.rs1_id;
        e.fib = s.rw_wb && s.rd_wb != 0 && s.rd_wb == s.rs2_id;
        e.wr = 3'b111; e.fl = 3'b000; e.abort = 0;
        lu = s.memread && s.rd_ex != 0 &&
             ((reads1(s.op) && s.rd_ex == s.rs1_id) || (reads2(s.op) && s.rd_ex == s.rs2_id));
        if (!m_wait) begin
            if (s.pcsrc) begin
                e.fl = 3'b110; m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
            end else if (s.start) begin
                m_wait = 1; m_waited = 0;
            end else if (lu) begin
                e.wr = 3'b001; e.fl = 3'b010;
                m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            end
        end else begin
            if (s.done) begin
                m_wait = 0;
            end else if (m_waited + 1 < T) begin
                e.wr = 3'b000; e.fl = 3'b001; m_waited++;
                m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            end else begin
                e.abort = 1; m_wait = 0;
            end
        end
    endtask

    // ---------------- driver ----------------
    function automatic stim_t idle();
        stim_t s;
        s.rst_n = 1; s.op = OP_JAL;
        s.rs1_id = 0; s.rs2_id = 0; s.rs1_ex = 0; s.rs2_ex = 0;
        s.rd_ex = 0; s.rd_mem = 0; s.rd_wb = 0;
        s.memread = 0; s.rw_ex = 0; s.rw_mem = 0; s.rw_wb = 0;
        s.pcsrc = 0; s.start = 0; s.done = 0;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        @(negedge clk);
        rst_n = s.rst_n; OPCODE_ID = s.op;
        RS1_ID = s.rs1_id; RS2_ID = s.rs2_id; RS1_EX = s.rs1_ex; RS2_EX = s.rs2_ex;
        RD_EX = s.rd_ex; RD_MEM = s.rd_mem; RD_WB = s.rd_wb;
        MemRead_EX = s.memread; RegWrite_EX = s.rw_ex;
        RegWrite_MEM = s.rw_mem; RegWrite_WB = s.rw_wb;
        PCSrc_EX = s.pcsrc; MDU_START_EX = s.start; MDU_DONE = s.done;
        model_step(s, e);
        #1 q.push_back(e);
    endtask

    task automatic do_reset(input int n);
        stim_t s;
        s = idle(); s.rst_n = 0;
        for (int i = 0; i < n; i++) apply(s);
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) apply(idle());
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("writes", {29'd0, PC_WRITE, IF_ID_WRITE, ID_EX_WRITE}, {29'd0, e.wr});
                chk("flushes", {29'd0, IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH}, {29'd0, e.fl});
                chk("fwd_ex", {28'd0, FWD_A, FWD_B}, {28'd0, e.fa, e.fb});
                chk("fwd_id", {30'd0, FWD_ID_A, FWD_ID_B}, {30'd0, e.fia, e.fib});
                chk("mdu_abort", {31'd0, MDU_ABORT}, {31'd0, e.abort});
                chk("stall_cnt", {{(32-CW){1'b0}}, STALL_CNT}, e.stall);
                chk("flush_cnt", {{(32-CW){1'b0}}, FLUSH_CNT}, e.flush);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : driver
        stim_t s;
        logic [6:0] ops [9];
        ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

        do_reset(2);
        // load-use: lw x5 in EX, add x6,x5,x1 in ID
        s = idle(); s.memread = 1; s.rd_ex = 5; s.op = OP_R; s.rs1_id = 5; s.rs2_id = 1;
        apply(s);
        idles(1);
        // same registers, LUI reads nothing
        s.op = OP_LUI; apply(s);
        // load into x0 never stalls
        s.op = OP_R; s.rd_ex = 0; s.rs1_id = 0; apply(s);
        // branch with concurrent load-use
        s = idle(); s.memread = 1; s.rd_ex = 5; s.op = OP_R; s.rs2_id = 5; s.pcsrc = 1;
        apply(s);
        // MDU issue beats load-use
        s.pcsrc = 0; s.start = 1; apply(s);
        idles(4);
        s = idle(); s.done = 1; apply(s);
        idles(1);

        do_reset(1);
        // MDU normal: DONE on 5th cycle after issue
        s = idle(); s.start = 1; apply(s);
        s = idle(); s.pcsrc = 1; s.memread = 1; s.rd_ex = 3; s.op = OP_I; s.rs1_id = 3;
        apply(s);
        idles(3);
        s = idle(); s.done = 1; apply(s);
        idles(1);
        // timeout: no DONE, abort on the 8th wait cycle
        s = idle(); s.start = 1; apply(s);
        idles(T);
        idles(1);
        // DONE on the timeout cycle: no abort
        s = idle(); s.start = 1; apply(s);
        idles(T - 1);
        s = idle(); s.done = 1; apply(s);
        idles(1);

        // forwarding
        s = idle(); s.rd_mem = 7; s.rd_wb = 7; s.rs1_ex = 7; s.rw_mem = 1; s.rw_wb = 1;
        apply(s);
        s = idle(); s.rd_mem = 0; s.rs1_ex = 0; s.rw_mem = 1; s.rd_wb = 0; s.rw_wb = 1;
        apply(s);
        s = idle(); s.rd_wb = 3; s.rs2_id = 3; s.rw_wb = 1; s.rs2_ex = 3; apply(s);
        s = idle(); s.rd_mem = 4; s.rs2_ex = 4; s.rw_mem = 0; s.rd_wb = 4; s.rw_wb = 1;
        s.rs1_id = 4; apply(s);

        // reset mid-wait
        s = idle(); s.start = 1; apply(s);
        idles(3);
        do_reset(2);
        idles(T + 1);

        // flush counter saturation
        s = idle(); s.pcsrc = 1;
        for (int i = 0; i < CMAX + 3; i++) apply(s);
        idles(2);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            s = idle();
            s.rst_n  = ($urandom_range(0, 79) != 0);
            s.op     = ops[$urandom_range(0, 8)];
            s.rs1_id = 5'($urandom_range(0, 7)); s.rs2_id = 5'($urandom_range(0, 7));
            s.rs1_ex = 5'($urandom_range(0, 7)); s.rs2_ex = 5'($urandom_range(0, 7));
            s.rd_ex  = 5'($urandom_range(0, 7)); s.rd_mem = 5'($urandom_range(0, 7));
            s.rd_wb  = 5'($urandom_range(0, 7));
            s.memread = ($urandom_range(0, 2) == 0);
            s.rw_ex  = 1'($urandom); s.rw_mem = 1'($urandom); s.rw_wb = 1'($urandom);
            s.pcsrc  = ($urandom_range(0, 5) == 0);
            s.start  = !s.pcsrc && ($urandom_range(0, 9) == 0);
            s.done   = m_wait && ($urandom_range(0, 4) == 0);
            // release cycles carry no concurrent branch or load
            if (m_wait && (s.done || m_waited + 1 >= T)) begin
                s.pcsrc = 0; s.memread = 0;
            end
            apply(s);
        end
        idles(2);

        repeat (3) @(negedge clk);
        #3;
        n_checks++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_hazard_ctrl
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core. Watches the decode stage register indices/opcode and the EX/MEM/WB destination info.
- Generates stall, flush and freeze strobes for PC, IF/ID, ID/EX and EX/MEM, plus forwarding selects for EX and a WB→ID bypass for register-file reads.
- Holds the pipeline while a multi-cycle multiply/divide unit (MDU) in EX is busy, with a timeout. Keeps saturating stall/flush performance counters.

Parameters:
- MDU_TIMEOUT, 64, max MDU_WAIT cycles before forced abort (≥2)
- CNT_W, 16, width of performance counters

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- OPCODE_ID  in  7  decode-stage opcode
- RS1_ID, RS2_ID  in  5 each  decode-stage source indices
- RS1_EX, RS2_EX  in  5 each  EX-stage source indices
- RD_EX, RD_MEM, RD_WB  in  5 each  destination indices per stage
- MemRead_EX  in  1  EX instruction is a load
- RegWrite_EX, RegWrite_MEM, RegWrite_WB  in  1 each  stage writes register file
- PCSrc_EX  in  1  branch/jump taken, resolved in EX
- MDU_START_EX  in  1  MDU op issued in EX this cycle
- MDU_DONE  in  1  MDU result valid
- PC_WRITE, IF_ID_WRITE, ID_EX_WRITE  out  1 each  register enables
- IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH  out  1 each  insert bubble
- FWD_A, FWD_B  out  2 each  EX operand select: 00 regfile, 01 WB, 10 MEM
- FWD_ID_A, FWD_ID_B  out  1 each  bypass ALU_DATA_WB into ID read data
- MDU_ABORT  out  1  one-cycle pulse on timeout
- STALL_CNT, FLUSH_CNT  out  CNT_W each  performance counters

Behaviour:
- Reset: asynchronous on rst_n low.
  - State=RUN; timeout counter=0; STALL_CNT=FLUSH_CNT=0; MDU_ABORT=0.
  - While rst_n low, strobes are forced: PC_WRITE=IF_ID_WRITE=ID_EX_WRITE=0; all FLUSH=1; FWD_*=0.
  - Reset mid-MDU_WAIT aborts silently to RUN. No MDU_ABORT pulse.
- Source usage, decoded from OPCODE_ID:
  - 0110011, 0100011, 1100011 use rs1 and rs2.
  - 1100111, 0010011, 0000011 use rs1 only.
  - All other opcodes use neither.
- Load-use hazard: MemRead_EX && RD_EX≠0 && RD_EX matches a used RS*_ID.
- Index x0 never matches in any hazard or forwarding compare.
- State RUN; all strobes combinational, zero latency. Priority is PCSrc_EX, then MDU_START_EX, then load-use.
  - PCSrc_EX=1: PC_WRITE=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1. Any concurrent load-use is ignored. FLUSH_CNT+1.
  - MDU_START_EX=1: next state MDU_WAIT; timeout counter←0. Same cycle strobes are normal (all writes 1, no flush).
  - Load-use: PC_WRITE=0, IF_ID_WRITE=0, ID_EX_FLUSH=1, ID_EX_WRITE=1. STALL_CNT+1. Exactly one bubble per hazard; the next cycle re-evaluates.
  - Otherwise: all *_WRITE=1, all FLUSH=0.
- State MDU_WAIT:
  - MDU_DONE=0 and counter<MDU_TIMEOUT-1:
    - PC_WRITE=IF_ID_WRITE=ID_EX_WRITE=0; EX_MEM_FLUSH=1.
    - Counter+1; STALL_CNT+1.
    - PCSrc_EX and load-use are ignored.
  - MDU_DONE=1: release this cycle (normal strobes, EX_MEM_FLUSH=0); next state RUN.
  - Counter reaches MDU_TIMEOUT-1 without MDU_DONE:
    - MDU_ABORT=1 that cycle; strobes as in a normal release.
    - Next state RUN.
  - MDU_DONE and timeout in the same cycle: DONE wins, no abort.
- Counters saturate at all-ones and never wrap.
- Forwarding, combinational in all states:
  - FWD_A=10 if RegWrite_MEM && RD_MEM≠0 && RD_MEM==RS1_EX.
  - Else FWD_A=01 if RegWrite_WB && RD_WB≠0 && RD_WB==RS1_EX.
  - Else FWD_A=00.
  - FWD_B is the same using RS2_EX.
  - FWD_ID_A=RegWrite_WB && RD_WB≠0 && RD_WB==RS1_ID; FWD_ID_B uses RS2_ID.

Decomposition:
- Shared package core_pkg:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - FWD_* encodings (FWD_REG, FWD_WB, FWD_MEM)
  - state encoding (ST_RUN, ST_MDU_WAIT)
- One natural sub-module, fwd_unit: purely combinational EX and ID forwarding selects, reusable by the verification model.
- FSM, hazard detect and counters stay in hazard_ctrl.

Test Plan:
- Load-use: `lw x5` in EX (MemRead_EX=1, RD_EX=5), `add x6,x5,x1` in ID → one cycle with PC_WRITE=0, IF_ID_WRITE=0, ID_EX_FLUSH=1, STALL_CNT=1. Same case with OPCODE_ID=LUI → no stall.
- Branch priority: PCSrc_EX=1 with a concurrent load-use → IF_ID_FLUSH=ID_EX_FLUSH=1, PC_WRITE=1, FLUSH_CNT=1, STALL_CNT unchanged.
- MDU normal: MDU_START_EX pulse, MDU_DONE on the 5th cycle after → 4 freeze cycles with EX_MEM_FLUSH=1, release on the DONE cycle, state RUN, STALL_CNT=4.
- MDU timeout: MDU_TIMEOUT=8, no DONE → MDU_ABORT high exactly on the 8th wait cycle, then RUN. DONE on that same cycle instead → no abort.
- Forwarding: RD_MEM=RD_WB=RS1_EX=7, both RegWrite=1 → FWD_A=10. RD_MEM=0 with RS1_EX=0 → FWD_A=00. RD_WB=RS2_ID=3, RegWrite_WB=1 → FWD_ID_B=1.
- Reset: assert rst_n low mid-MDU_WAIT → immediate RUN, counters 0, FLUSH outputs 1 while low, no MDU_ABORT. Preload FLUSH_CNT to all-ones → stays saturated.
